// File: rtl/game_step_ctrl.sv
// game_step_ctrl: sequences player commands into single committed updates of
// the game state, drives the move engine handshake and keeps the step counter
// and win / timeout status for the display.
module game_step_ctrl #(
  parameter int TIMEOUT  = 15,
  parameter int STEP_MAX = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [2:0] key_code,
  input  logic       move_done,
  input  logic       move_legal,
  input  logic       real_retract,
  input  logic       win,
  output logic [1:0] sel,
  output logic       game_state_en,
  output logic       move_start,
  output logic [1:0] move_dir,
  output logic       busy,
  output logic [9:0] step_count,
  output logic       won,
  output logic       move_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    RST_LOAD,
    LOAD,
    IDLE,
    MOVE_WAIT,
    COMMIT,
    RETRACT,
    RR_CHECK,
    WIN_CHECK,
    WON
  } state_t;

  localparam logic [1:0] SEL_LOAD    = 2'd0;
  localparam logic [1:0] SEL_COMMIT  = 2'd1;
  localparam logic [1:0] SEL_RETRACT = 2'd2;
  localparam logic [1:0] SEL_HOLD    = 2'd3;

  state_t          state, state_n;
  logic [TW-1:0]   tcount, tcount_n;
  logic [1:0]      sel_n;
  logic            en_n;
  logic            start_n;
  logic [1:0]      dir_n;
  logic            busy_n;
  logic [9:0]      step_n;
  logic            won_n;
  logic            err_n;

  // State, timeout counter and all outputs are registered from the next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RST_LOAD;
      tcount        <= '0;
      sel           <= SEL_HOLD;
      game_state_en <= 1'b0;
      move_start    <= 1'b0;
      move_dir      <= 2'd0;
      busy          <= 1'b1;
      step_count    <= 10'd0;
      won           <= 1'b0;
      move_err      <= 1'b0;
    end else begin
      state         <= state_n;
      tcount        <= tcount_n;
      sel           <= sel_n;
      game_state_en <= en_n;
      move_start    <= start_n;
      move_dir      <= dir_n;
      busy          <= busy_n;
      step_count    <= step_n;
      won           <= won_n;
      move_err      <= err_n;
    end
  end

  // Next state plus the output values belonging to the state being entered,
  // so the enable and select line up with the cycle spent in that state.
  always_comb begin
    state_n  = state;
    tcount_n = tcount;
    sel_n    = SEL_HOLD;
    en_n     = 1'b0;
    start_n  = 1'b0;
    dir_n    = move_dir;
    step_n   = step_count;
    won_n    = won;
    err_n    = move_err;

    case (state)
      RST_LOAD: state_n = LOAD;
      LOAD:     state_n = IDLE;
      IDLE: begin
        if (key_valid) begin
          case (key_code)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              dir_n    = key_code[1:0];
              start_n  = 1'b1;
              tcount_n = '0;
              state_n  = MOVE_WAIT;
            end
            3'd4:    state_n = RETRACT;
            3'd5:    state_n = LOAD;
            default: state_n = IDLE;
          endcase
        end
      end
      MOVE_WAIT: begin
        if (move_done) begin
          state_n = move_legal ? COMMIT : IDLE;
        end else if (tcount == TW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          tcount_n = tcount + TW'(1);
        end
      end
      COMMIT: begin
        if (step_count < 10'(STEP_MAX)) begin
          step_n = step_count + 10'd1;
        end
        state_n = WIN_CHECK;
      end
      WIN_CHECK: begin
        if (win) begin
          state_n = WON;
          won_n   = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RETRACT: state_n = RR_CHECK;
      RR_CHECK: begin
        if (real_retract && (step_count != 10'd0)) begin
          step_n = step_count - 10'd1;
        end
        state_n = IDLE;
      end
      WON: begin
        if (key_valid && (key_code == 3'd5)) begin
          state_n = LOAD;
        end
      end
      default: state_n = RST_LOAD;
    endcase

    case (state_n)
      LOAD: begin
        sel_n  = SEL_LOAD;
        en_n   = 1'b1;
        step_n = 10'd0;
        won_n  = 1'b0;
        err_n  = 1'b0;
      end
      COMMIT: begin
        sel_n = SEL_COMMIT;
        en_n  = 1'b1;
      end
      RETRACT: begin
        sel_n = SEL_RETRACT;
        en_n  = 1'b1;
      end
      default: begin
        sel_n = SEL_HOLD;
        en_n  = 1'b0;
      end
    endcase

    busy_n = !((state_n == IDLE) || (state_n == WON));
  end

endmodule

// File: tb/tb_game_step_ctrl.sv
// Directed testbench for game_step_ctrl: a cycle-by-cycle vector table for the
// main command flows plus hand-written sequences for timeout, saturation and
// reset in the middle of a commit.
module tb_game_step_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [2:0] key_code;
  logic       move_done;
  logic       move_legal;
  logic       real_retract;
  logic       win;
  logic [1:0] sel;
  logic       game_state_en;
  logic       move_start;
  logic [1:0] move_dir;
  logic       busy;
  logic [9:0] step_count;
  logic       won;
  logic       move_err;

  int checks = 0;
  int errors = 0;

  // Small saturation value so the ceiling is reachable in a few moves.
  game_step_ctrl #(.TIMEOUT(15), .STEP_MAX(3)) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .move_done(move_done),
    .move_legal(move_legal),
    .real_retract(real_retract),
    .win(win),
    .sel(sel),
    .game_state_en(game_state_en),
    .move_start(move_start),
    .move_dir(move_dir),
    .busy(busy),
    .step_count(step_count),
    .won(won),
    .move_err(move_err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       kv;
    logic [2:0] kc;
    logic       md;
    logic       ml;
    logic       rr;
    logic       wn;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [18:0] packOut(logic [1:0] s, logic e, logic ms, logic [1:0] d,
                                          logic b, logic [9:0] st, logic w, logic er);
    return {s, e, ms, d, b, st, w, er};
  endfunction

  function automatic logic [18:0] dutOuts();
    return {sel, game_state_en, move_start, move_dir, busy, step_count, won, move_err};
  endfunction

  task automatic addV(input string n, input logic kv, input logic [2:0] kc, input logic md,
                      input logic ml, input logic rr, input logic wn, input logic [1:0] s,
                      input logic e, input logic ms, input logic [1:0] d, input logic b,
                      input logic [9:0] st, input logic w, input logic er);
    vec_t v;
    v.name = n; v.kv = kv; v.kc = kc; v.md = md; v.ml = ml; v.rr = rr; v.wn = wn;
    v.exp = packOut(s, e, ms, d, b, st, w, er);
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string n, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then sample.
  task automatic applyStimulus(input logic kv, input logic [2:0] kc, input logic md,
                               input logic ml, input logic rr, input logic wn);
    key_valid = kv; key_code = kc; move_done = md; move_legal = ml;
    real_retract = rr; win = wn;
    @(posedge clk);
    #1;
  endtask

  logic en_seen;

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("reset_values", dutOuts(), packOut(2'd3, 0, 0, 2'd0, 1, 10'd0, 0, 0));
    rst = 1'b0;

    //    name               kv kc md ml rr wn   sel en ms dir busy steps won err
    addV("load",             0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0, 0);
    addV("idle",             0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0);
    addV("key_right",        1, 3, 0, 0, 0, 0,   3, 0, 1, 3, 1, 0, 0, 0);
    addV("wait1",            0, 0, 0, 0, 0, 0,   3, 0, 0, 3, 1, 0, 0, 0);
    addV("wait2",            0, 0, 0, 0, 0, 0,   3, 0, 0, 3, 1, 0, 0, 0);
    addV("wait3",            0, 0, 0, 0, 0, 0,   3, 0, 0, 3, 1, 0, 0, 0);
    addV("done_legal",       0, 0, 1, 1, 0, 0,   1, 1, 0, 3, 1, 0, 0, 0);
    addV("win_check",        0, 0, 0, 0, 0, 0,   3, 0, 0, 3, 1, 1, 0, 0);
    addV("back_idle",        0, 0, 0, 0, 0, 0,   3, 0, 0, 3, 0, 1, 0, 0);
    addV("key_up",           1, 0, 0, 0, 0, 0,   3, 0, 1, 0, 1, 1, 0, 0);
    addV("drop_in_wait",     1, 4, 0, 0, 0, 0,   3, 0, 0, 0, 1, 1, 0, 0);
    addV("done2",            0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 1, 1, 0, 0);
    addV("stray_done",       0, 0, 1, 1, 0, 0,   3, 0, 0, 0, 1, 2, 0, 0);
    addV("idle2",            0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 2, 0, 0);
    addV("retract",          1, 4, 0, 0, 0, 0,   2, 1, 0, 0, 1, 2, 0, 0);
    addV("drop_in_retract",  1, 0, 0, 0, 0, 0,   3, 0, 0, 0, 1, 2, 0, 0);
    addV("rr_dec",           0, 0, 0, 0, 1, 0,   3, 0, 0, 0, 0, 1, 0, 0);
    addV("retract2",         1, 4, 0, 0, 0, 0,   2, 1, 0, 0, 1, 1, 0, 0);
    addV("rr_wait",          0, 0, 0, 0, 1, 0,   3, 0, 0, 0, 1, 1, 0, 0);
    addV("rr_nodec",         0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 1, 0, 0);
    addV("key_left",         1, 2, 0, 0, 0, 0,   3, 0, 1, 2, 1, 1, 0, 0);
    addV("done_illegal",     0, 0, 1, 0, 0, 0,   3, 0, 0, 2, 0, 1, 0, 0);
    addV("code6",            1, 6, 0, 0, 0, 0,   3, 0, 0, 2, 0, 1, 0, 0);
    addV("code7",            1, 7, 0, 0, 0, 0,   3, 0, 0, 2, 0, 1, 0, 0);
    addV("retract3",         1, 4, 0, 0, 0, 0,   2, 1, 0, 2, 1, 1, 0, 0);
    addV("rr_wait3",         0, 0, 0, 0, 0, 0,   3, 0, 0, 2, 1, 1, 0, 0);
    addV("rr_to_zero",       0, 0, 0, 0, 1, 0,   3, 0, 0, 2, 0, 0, 0, 0);
    addV("retract4",         1, 4, 0, 0, 0, 0,   2, 1, 0, 2, 1, 0, 0, 0);
    addV("rr_wait4",         0, 0, 0, 0, 0, 0,   3, 0, 0, 2, 1, 0, 0, 0);
    addV("no_underflow",     0, 0, 0, 0, 1, 0,   3, 0, 0, 2, 0, 0, 0, 0);
    addV("key_down",         1, 1, 0, 0, 0, 0,   3, 0, 1, 1, 1, 0, 0, 0);
    addV("done_win",         0, 0, 1, 1, 0, 0,   1, 1, 0, 1, 1, 0, 0, 0);
    addV("win_check2",       0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 1, 1, 0, 0);
    addV("to_won",           0, 0, 0, 0, 0, 1,   3, 0, 0, 1, 0, 1, 1, 0);
    addV("won_drop0",        1, 0, 0, 0, 0, 0,   3, 0, 0, 1, 0, 1, 1, 0);
    addV("won_drop4",        1, 4, 0, 0, 0, 0,   3, 0, 0, 1, 0, 1, 1, 0);
    addV("won_reload",       1, 5, 0, 0, 0, 0,   0, 1, 0, 1, 1, 0, 0, 0);
    addV("idle3",            0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].kv, vecs[i].kc, vecs[i].md, vecs[i].ml, vecs[i].rr, vecs[i].wn);
      checkOutput(vecs[i].name, dutOuts(), vecs[i].exp);
    end

    // Timeout: key up with no move_done; error must rise on the 15th edge
    // after the start pulse and no enable may appear meanwhile.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("to_start", {18'd0, move_start}, 19'd1);
    en_seen = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      en_seen = en_seen | game_state_en;
      if (i == 14) checkOutput("to_not_yet", {18'd0, move_err}, 19'd0);
    end
    checkOutput("to_err", {17'd0, move_err, busy}, {17'd0, 1'b1, 1'b0});
    checkOutput("to_no_enable", {18'd0, en_seen}, 19'd0);
    applyStimulus(1, 5, 0, 0, 0, 0);
    checkOutput("to_reload", dutOuts(), packOut(2'd0, 1, 0, 2'd0, 1, 10'd0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Saturation: four legal moves against a ceiling of three.
    for (int m = 0; m < 4; m++) begin
      applyStimulus(1, 3, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (m == 2) checkOutput("sat_three", {9'd0, step_count}, 19'd3);
    end
    checkOutput("sat_hold", {9'd0, step_count}, 19'd3);

    // Reset asserted during the commit cycle, then a fresh load sequence.
    applyStimulus(1, 2, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("commit_seen", {17'd0, sel}, {17'd0, 2'd1});
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_reset", dutOuts(), packOut(2'd3, 0, 0, 2'd0, 1, 10'd0, 0, 0));
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("reload_after_rst", dutOuts(), packOut(2'd0, 1, 0, 2'd0, 1, 10'd0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("idle_after_rst", dutOuts(), packOut(2'd3, 0, 0, 2'd0, 0, 10'd0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
